delay_probe: RTL and testbench

DELAY_PROBE -- requirements
Module: delay_probe

---
 rtl/delay_probe_pkg.sv | 41 ++++
 rtl/delay_probe_btn_debounce.sv | 66 ++++++
 rtl/delay_probe.sv | 127 ++++++++++++
 tb/tb_delay_probe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_probe_pkg.sv
// Shared types and elaboration-time sizing helpers for the delay-line probe.
package delay_probe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUIET = 2'd1,
    PULSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int len_w(input int max_len);
    return (max_len < 1) ? 1 : $clog2(max_len + 1);
  endfunction

  function automatic int cnt_w(input int max_len);
    return $clog2(max_len + 4);
  endfunction

  // Quiet time flushes every stage of the line plus the registered output.
  function automatic int quiet_cyc(input int max_len);
    return max_len + 4;
  endfunction

  function automatic int timeout_cyc(input int max_len);
    return max_len + 3;
  endfunction

  function automatic int db_cycles(input int clock_hz, input int debounce_ms);
    int n;
    n = (clock_hz / 1000) * debounce_ms;
    return (n < 1) ? 1 : n;
  endfunction

  // A return sampled at edge launch+L+2 means setting L; clamp to the legal range.
  function automatic int sat_len(input int raw, input int max_len);
    if (raw < 2) return 0;
    if (raw - 2 > max_len) return max_len;
    return raw - 2;
  endfunction

endpackage

// File: rtl/delay_probe_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-time debounce, rise pulse.
// After reset the button must be seen released before any press is reported.
module btn_debounce
  import delay_probe_pkg::*;
#(
  parameter int CLOCK_HZ    = 12_000_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic ext_clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int DB_N = db_cycles(CLOCK_HZ, DEBOUNCE_MS);
  localparam int DB_W = $clog2(DB_N + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_armed;
  logic            r_rise;
  logic [DB_W-1:0] r_cnt;

  logic w_ref;
  logic w_differ;
  logic w_settled;

  // Until armed, treat the level as pressed so a held button cannot start a run.
  assign w_ref     = r_armed ? r_level : 1'b1;
  assign w_differ  = (r_sync2 != w_ref);
  assign w_settled = w_differ && (r_cnt == DB_W'(DB_N - 1));

  // NOTE: async active-low reset clears every flop, synchroniser included.
  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_settled) begin
        r_cnt <= '0;
        if (!r_armed) begin
          r_armed <= 1'b1;
        end else begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
        end
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/delay_probe.sv
// Measures a delay line: flushes it, launches a step on tx_bit and counts
// edges until the step returns on rx_bit, reporting raw count and setting.
module delay_probe
  import delay_probe_pkg::*;
#(
  parameter  int MAX_LEN     = 15,
  parameter  int CLOCK_HZ    = 12_000_000,
  parameter  int DEBOUNCE_MS = 10,
  localparam int CNT_W       = cnt_w(MAX_LEN),
  localparam int LEN_W       = len_w(MAX_LEN)
) (
  input  logic             ext_clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic             rx_bit,
  output logic             tx_bit,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_raw,
  output logic [LEN_W-1:0] meas_len,
  output logic             timeout,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(quiet_cyc(MAX_LEN) - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(timeout_cyc(MAX_LEN));

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [LEN_W-1:0] w_len_sat;
  logic             r_tx_bit;
  logic [CNT_W-1:0] r_meas_raw;
  logic [LEN_W-1:0] r_meas_len;
  logic             r_timeout;
  logic             r_stuck;
  logic             w_start;

  btn_debounce #(
    .CLOCK_HZ   (CLOCK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_btn (
    .ext_clk(ext_clk),
    .rst_n  (rst_n),
    .i_btn  (btn),
    .o_rise (w_start)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_len_sat = LEN_W'(sat_len(int'(w_cnt_inc), MAX_LEN));

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_next_state = QUIET;
      QUIET: begin
        if (rx_bit)                   w_next_state = DONE;
        else if (r_cnt == QUIET_LAST) w_next_state = PULSE;
      end
      // A return on the timeout edge still lands in DONE as a capture below.
      PULSE:   if (rx_bit || (w_cnt_inc == TIMEOUT_VAL)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != IDLE);
    meas_valid = (r_state == DONE);
  end

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_tx_bit   <= 1'b0;
      r_meas_raw <= '0;
      r_meas_len <= '0;
      r_timeout  <= 1'b0;
      r_stuck    <= 1'b0;
    end else begin
      r_tx_bit <= (w_next_state == PULSE);
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
            r_stuck    <= 1'b0;
            r_meas_raw <= '0;
            r_meas_len <= '0;
          end
        end
        QUIET: begin
          if (rx_bit)                   r_stuck <= 1'b1;
          else if (r_cnt == QUIET_LAST) r_cnt   <= '0;
          else                          r_cnt   <= w_cnt_inc;
        end
        PULSE: begin
          if (rx_bit) begin
            r_meas_raw <= w_cnt_inc;
            r_meas_len <= w_len_sat;
          end else if (w_cnt_inc == TIMEOUT_VAL) begin
            r_timeout  <= 1'b1;
            r_meas_raw <= '0;
            r_meas_len <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_bit   = r_tx_bit;
  assign meas_raw = r_meas_raw;
  assign meas_len = r_meas_len;
  assign timeout  = r_timeout;
  assign stuck    = r_stuck;

endmodule

// File: tb/tb_delay_probe.sv
// Directed bench for delay_probe: a modelled delay line (L+1 register stages)
// or a tied rx_bit, a table of single runs, then hand-written corner sequences.
module tb_delay_probe;

  logic       ext_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       btn     = 1'b0;
  logic       rx_bit;
  logic       tx_bit;
  logic       busy;
  logic       meas_valid;
  logic [4:0] meas_raw;
  logic [3:0] meas_len;
  logic       timeout;
  logic       stuck;

  delay_probe #(
    .MAX_LEN    (15),
    .CLOCK_HZ   (1000),
    .DEBOUNCE_MS(4)
  ) dut (
    .ext_clk   (ext_clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .rx_bit    (rx_bit),
    .tx_bit    (tx_bit),
    .busy      (busy),
    .meas_valid(meas_valid),
    .meas_raw  (meas_raw),
    .meas_len  (meas_len),
    .timeout   (timeout),
    .stuck     (stuck)
  );

  always #5 ext_clk = ~ext_clk;

  // mode 0: delay line of setting len; mode 1: rx tied 0; mode 2: rx tied 1
  int          mode = 1;
  int          len  = 0;
  logic [16:0] dl;

  always @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) dl <= '0;
    else        dl <= {dl[15:0], tx_bit};
  end

  assign rx_bit = (mode == 0) ? dl[len] : (mode == 2);

  int n_valid     = 0;
  int n_tx        = 0;
  int n_busy_rise = 0;
  bit prev_busy   = 1'b0;

  always @(negedge ext_clk) begin
    if (meas_valid) n_valid++;
    if (tx_bit) n_tx++;
    if (busy && !prev_busy) n_busy_rise++;
    prev_busy = busy;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge ext_clk);
  endtask

  // sel 0: busy, 1: tx_bit, 2: meas_valid
  task automatic wait_for(input int sel, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge ext_clk);
      if ((sel == 0 && busy) || (sel == 1 && tx_bit) || (sel == 2 && meas_valid)) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  typedef struct {
    int mode;
    int len;
    int exp_raw;
    int exp_len;
    int exp_to;
    int exp_stuck;
    int exp_tx;
  } vec_t;

  task automatic run_vector(input vec_t v, input int idx);
    int v0, t0, b0;
    mode = v.mode;
    len  = v.len;
    v0 = n_valid;
    t0 = n_tx;
    b0 = n_busy_rise;
    @(negedge ext_clk);
    btn = 1'b1;
    wait_for(2, $sformatf("v%0d_valid_seen", idx));
    check($sformatf("v%0d_raw", idx), meas_raw, v.exp_raw);
    check($sformatf("v%0d_len", idx), meas_len, v.exp_len);
    check($sformatf("v%0d_timeout", idx), timeout, v.exp_to);
    check($sformatf("v%0d_stuck", idx), stuck, v.exp_stuck);
    check($sformatf("v%0d_tx_in_done", idx), tx_bit, 0);
    @(negedge ext_clk);
    check($sformatf("v%0d_busy_after", idx), busy, 0);
    check($sformatf("v%0d_valid_once", idx), meas_valid, 0);
    btn = 1'b0;
    cycles(12);
    check($sformatf("v%0d_valid_pulses", idx), n_valid - v0, 1);
    check($sformatf("v%0d_tx_cycles", idx), n_tx - t0, v.exp_tx);
    check($sformatf("v%0d_runs", idx), n_busy_rise - b0, 1);
    check($sformatf("v%0d_raw_held", idx), meas_raw, v.exp_raw);
  endtask

  vec_t vecs[7];
  int   v0, b0;

  initial begin
    //            mode len raw len to stk tx
    vecs[0] = '{0,  0,  2,  0, 0, 0,  2};
    vecs[1] = '{0, 15, 17, 15, 0, 0, 17};
    vecs[2] = '{0,  5,  7,  5, 0, 0,  7};
    vecs[3] = '{0, 10, 12, 10, 0, 0, 12};
    vecs[4] = '{0, 16, 18, 15, 0, 0, 18};
    vecs[5] = '{1,  0,  0,  0, 1, 0, 18};
    vecs[6] = '{2,  0,  0,  0, 0, 1,  0};

    #1;
    check("rst_tx", tx_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_raw", meas_raw, 0);
    check("rst_len", meas_len, 0);
    check("rst_timeout", timeout, 0);
    check("rst_stuck", stuck, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(12);
    check("idle_no_start", busy, 0);

    for (int i = 0; i < 7; i++) run_vector(vecs[i], i);

    // Second press during PULSE is ignored; one result only.
    mode = 0;
    len  = 15;
    v0 = n_valid;
    b0 = n_busy_rise;
    btn = 1'b1;
    wait_for(0, "dbl_busy_seen");
    btn = 1'b0;
    wait_for(1, "dbl_tx_seen");
    btn = 1'b1;
    wait_for(2, "dbl_valid_seen");
    check("dbl_raw", meas_raw, 17);
    check("dbl_len", meas_len, 15);
    cycles(30);
    check("dbl_valid_pulses", n_valid - v0, 1);
    check("dbl_runs", n_busy_rise - b0, 1);
    check("dbl_idle", busy, 0);

    // Reset mid-PULSE aborts with every output cleared and no result.
    btn = 1'b0;
    cycles(12);
    v0 = n_valid;
    b0 = n_busy_rise;
    btn = 1'b1;
    wait_for(1, "abort_tx_seen");
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", tx_bit, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", meas_valid, 0);
    check("abort_raw", meas_raw, 0);
    check("abort_len", meas_len, 0);
    check("abort_timeout", timeout, 0);
    check("abort_stuck", stuck, 0);
    @(negedge ext_clk);
    rst_n = 1'b1;
    cycles(30);
    check("abort_no_valid", n_valid - v0, 0);
    check("abort_held_btn_no_run", n_busy_rise - b0, 1);
    check("abort_idle", busy, 0);

    // Bouncing press yields exactly one run.
    btn = 1'b0;
    cycles(12);
    mode = 0;
    len  = 3;
    v0 = n_valid;
    b0 = n_busy_rise;
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      cycles(2);
    end
    check("bounce_no_early_run", n_busy_rise - b0, 0);
    btn = 1'b1;
    wait_for(2, "bounce_valid_seen");
    check("bounce_raw", meas_raw, 5);
    check("bounce_len", meas_len, 3);
    cycles(30);
    check("bounce_valid_pulses", n_valid - v0, 1);
    check("bounce_runs", n_busy_rise - b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
